// File: rtl/mts_cross_product_pipe.sv
// Pipelined hidden-bit mantissa outer product with truncate/RNE rounding.
// Latency 3 cycles, 1 pair/cycle; in_ready is combinational from out_ready, so a full stalled pipe holds.
module mts_cross_product_pipe #(
    parameter int MAT_SIZE_1 = 16,
    parameter int MAT_SIZE_2 = 16,
    parameter int FP_MANT_W  = 23,
    parameter int RND_EN     = 1
) (
    input  logic                                     clk,
    input  logic                                     rstnn,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     in_mode,
    input  logic [FP_MANT_W*MAT_SIZE_1-1:0]          vec_1,
    input  logic [FP_MANT_W*MAT_SIZE_2-1:0]          vec_2,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [FP_MANT_W*MAT_SIZE_1*MAT_SIZE_2-1:0] mant_matrix,
    output logic [MAT_SIZE_1*MAT_SIZE_2-1:0]         bump_matrix,
    output logic [MAT_SIZE_1*MAT_SIZE_2-1:0]         inexact_matrix,
    output logic                                     busy
);

    localparam int W  = FP_MANT_W;
    localparam int NE = MAT_SIZE_1 * MAT_SIZE_2;
    localparam int PW = 2 * W + 2;

    typedef struct packed {
        logic [W-1:0] mant;
        logic         bump;
        logic         inex;
    } elem_t;

    function automatic logic [PW-1:0] mul_elem(input logic [W-1:0] f1, input logic [W-1:0] f2);
        logic [PW-1:0] x1;
        logic [PW-1:0] x2;
        x1 = {{(W+1){1'b0}}, 1'b1, f1};
        x2 = {{(W+1){1'b0}}, 1'b1, f2};
        return x1 * x2;
    endfunction

    // A carry out of norm+inc can only happen when norm is all ones, so the
    // wrapped W-bit sum is already the required zero mantissa.
    function automatic elem_t round_elem(input logic [PW-1:0] p, input logic rne);
        elem_t      r;
        logic       bump0;
        logic [W:0] norm;
        logic       half;
        logic       sticky;
        logic       inc;
        bump0  = p[PW-1];
        norm   = bump0 ? p[PW-1:W+1] : p[PW-2:W];
        half   = bump0 ? p[W]        : p[W-1];
        sticky = bump0 ? |p[W-1:0]   : |p[W-2:0];
        inc    = rne & half & (sticky | norm[0]);
        r.mant = norm[W-1:0] + {{(W-1){1'b0}}, inc};
        r.bump = bump0 | (inc & (&norm));
        r.inex = half | sticky;
        return r;
    endfunction

    logic adv0, adv1, adv2;
    logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic mode0_q, mode0_d, mode1_q, mode1_d;
    logic [W*MAT_SIZE_1-1:0] vec_1_q, vec_1_d;
    logic [W*MAT_SIZE_2-1:0] vec_2_q, vec_2_d;
    logic [PW-1:0]           prod_q [NE];
    logic [PW-1:0]           prod_d [NE];
    logic [W*NE-1:0]         mant_q, mant_d;
    logic [NE-1:0]           bump_q, bump_d;
    logic [NE-1:0]           inex_q, inex_d;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign adv0     = !v0_q || adv1;
    assign in_ready = adv0;

    always_comb begin
        v0_d    = adv0 ? in_valid : v0_q;
        vec_1_d = vec_1_q;
        vec_2_d = vec_2_q;
        mode0_d = mode0_q;
        if (adv0 && in_valid) begin
            vec_1_d = vec_1;
            vec_2_d = vec_2;
            mode0_d = (RND_EN != 0) ? in_mode : 1'b0;
        end
    end

    always_comb begin
        v1_d    = adv1 ? v0_q : v1_q;
        mode1_d = mode1_q;
        prod_d  = prod_q;
        if (adv1 && v0_q) begin
            mode1_d = mode0_q;
            for (int i = 0; i < MAT_SIZE_1; i++) begin
                for (int j = 0; j < MAT_SIZE_2; j++) begin
                    prod_d[i*MAT_SIZE_2+j] = mul_elem(vec_1_q[i*W +: W], vec_2_q[j*W +: W]);
                end
            end
        end
    end

    always_comb begin
        elem_t e;
        e      = '0;
        v2_d   = adv2 ? v1_q : v2_q;
        mant_d = mant_q;
        bump_d = bump_q;
        inex_d = inex_q;
        if (adv2 && v1_q) begin
            for (int k = 0; k < NE; k++) begin
                e                = round_elem(prod_q[k], mode1_q);
                mant_d[k*W +: W] = e.mant;
                bump_d[k]        = e.bump;
                inex_d[k]        = e.inex;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            mode0_q <= 1'b0;
            mode1_q <= 1'b0;
            vec_1_q <= '0;
            vec_2_q <= '0;
            for (int k = 0; k < NE; k++) begin
                prod_q[k] <= '0;
            end
            mant_q  <= '0;
            bump_q  <= '0;
            inex_q  <= '0;
        end else begin
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            mode0_q <= mode0_d;
            mode1_q <= mode1_d;
            vec_1_q <= vec_1_d;
            vec_2_q <= vec_2_d;
            prod_q  <= prod_d;
            mant_q  <= mant_d;
            bump_q  <= bump_d;
            inex_q  <= inex_d;
        end
    end

    assign out_valid      = v2_q;
    assign mant_matrix    = mant_q;
    assign bump_matrix    = bump_q;
    assign inexact_matrix = inex_q;
    assign busy           = v0_q || v1_q || v2_q;

endmodule

// File: tb/tb_mts_cross_product_pipe.sv
// Scoreboard bench for mts_cross_product_pipe: default 16x16x23 instance plus a 2x3x10 instance.
module tb_mts_cross_product_pipe;

    localparam int N1 = 16, N2 = 16, W = 23, NE = N1 * N2;
    localparam int BN1 = 2, BN2 = 3, BW = 10, BNE = BN1 * BN2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstnn;

    logic a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_busy;
    logic [W*N1-1:0] a_vec_1;
    logic [W*N2-1:0] a_vec_2;
    logic [W*NE-1:0] a_mant;
    logic [NE-1:0]   a_bump, a_inex;

    logic b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_busy;
    logic [BW*BN1-1:0] b_vec_1;
    logic [BW*BN2-1:0] b_vec_2;
    logic [BW*BNE-1:0] b_mant;
    logic [BNE-1:0]    b_bump, b_inex;

    mts_cross_product_pipe dut_a (
        .clk(clk), .rstnn(rstnn), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .vec_1(a_vec_1), .vec_2(a_vec_2), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .mant_matrix(a_mant), .bump_matrix(a_bump),
        .inexact_matrix(a_inex), .busy(a_busy)
    );

    mts_cross_product_pipe #(.MAT_SIZE_1(BN1), .MAT_SIZE_2(BN2), .FP_MANT_W(BW), .RND_EN(1)) dut_b (
        .clk(clk), .rstnn(rstnn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .vec_1(b_vec_1), .vec_2(b_vec_2), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .mant_matrix(b_mant), .bump_matrix(b_bump),
        .inexact_matrix(b_inex), .busy(b_busy)
    );

    typedef struct packed {
        logic [W*NE-1:0] mant;
        logic [NE-1:0]   bump;
        logic [NE-1:0]   inex;
    } a_exp_t;

    typedef struct packed {
        logic [BW*BNE-1:0] mant;
        logic [BNE-1:0]    bump;
        logic [BNE-1:0]    inex;
    } b_exp_t;

    a_exp_t a_q[$];
    b_exp_t b_q[$];
    int checks = 0;
    int errors = 0;
    int a_rmode = 0;

    // Reference: exact integer product of the two significands, scaled and rounded.
    function automatic void ref_elem(input int w, input longint f1, input longint f2, input bit rne,
                                     output longint mant, output bit bump, output bit inex);
        longint one, p, q, r, half;
        int sh;
        one = longint'(1) << w;
        p   = (one + f1) * (one + f2);
        if (p >= (longint'(1) << (2*w+1))) begin sh = w + 1; bump = 1'b1; end
        else begin sh = w; bump = 1'b0; end
        q    = p >> sh;
        r    = p - (q << sh);
        half = longint'(1) << (sh - 1);
        inex = (r != 0);
        if (rne && (r > half || (r == half && (q % 2) == 1))) q = q + 1;
        if (q == (longint'(1) << (w+1))) begin mant = 0; bump = 1'b1; end
        else mant = q % one;
    endfunction

    function automatic a_exp_t mk_a(input logic [W*N1-1:0] v1, input logic [W*N2-1:0] v2, input bit rne);
        a_exp_t e;
        longint m; bit bp, ix;
        e = '0;
        for (int i = 0; i < N1; i++)
            for (int j = 0; j < N2; j++) begin
                ref_elem(W, longint'(v1[i*W +: W]), longint'(v2[j*W +: W]), rne, m, bp, ix);
                e.mant[(i*N2+j)*W +: W] = W'(m);
                e.bump[i*N2+j] = bp;
                e.inex[i*N2+j] = ix;
            end
        return e;
    endfunction

    function automatic b_exp_t mk_b(input logic [BW*BN1-1:0] v1, input logic [BW*BN2-1:0] v2, input bit rne);
        b_exp_t e;
        longint m; bit bp, ix;
        e = '0;
        for (int i = 0; i < BN1; i++)
            for (int j = 0; j < BN2; j++) begin
                ref_elem(BW, longint'(v1[i*BW +: BW]), longint'(v2[j*BW +: BW]), rne, m, bp, ix);
                e.mant[(i*BN2+j)*BW +: BW] = BW'(m);
                e.bump[i*BN2+j] = bp;
                e.inex[i*BN2+j] = ix;
            end
        return e;
    endfunction

    function automatic longint relm(input int w);
        int s;
        longint msk;
        s   = $urandom_range(0, 5);
        msk = (longint'(1) << w) - 1;
        case (s)
            0: return msk;
            1: return 0;
            2: return 1;
            default: return longint'($urandom) & msk;
        endcase
    endfunction

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic cmp_a(input string name, input a_exp_t e);
        int bad = -1;
        for (int k = 0; k < NE; k++)
            if (bad < 0 && (a_mant[k*W +: W] !== e.mant[k*W +: W] ||
                            a_bump[k] !== e.bump[k] || a_inex[k] !== e.inex[k])) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s elem %0d: got mant=%h bump=%b inex=%b, want mant=%h bump=%b inex=%b",
                     name, bad, a_mant[bad*W +: W], a_bump[bad], a_inex[bad],
                     e.mant[bad*W +: W], e.bump[bad], e.inex[bad]);
        end
    endtask

    task automatic cmp_b(input string name, input b_exp_t e);
        int bad = -1;
        for (int k = 0; k < BNE; k++)
            if (bad < 0 && (b_mant[k*BW +: BW] !== e.mant[k*BW +: BW] ||
                            b_bump[k] !== e.bump[k] || b_inex[k] !== e.inex[k])) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s elem %0d: got mant=%h bump=%b inex=%b, want mant=%h bump=%b inex=%b",
                     name, bad, b_mant[bad*BW +: BW], b_bump[bad], b_inex[bad],
                     e.mant[bad*BW +: BW], e.bump[bad], e.inex[bad]);
        end
    endtask

    // Called and returning at posedge+1; handshake sampled mid-cycle.
    task automatic a_send(input logic [W*N1-1:0] v1, input logic [W*N2-1:0] v2, input bit mode);
        int t = 0;
        bit done = 0;
        a_in_valid = 1'b1; a_vec_1 = v1; a_vec_2 = v2; a_in_mode = mode;
        while (!done) begin
            @(negedge clk); #1;
            if (a_in_ready) begin
                a_q.push_back(mk_a(v1, v2, mode));
                done = 1;
            end else if (++t > 200) begin
                checks++; errors++;
                $display("FAIL a_send_timeout: in_ready low for %0d cycles, required 1", t);
                done = 1;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [BW*BN1-1:0] v1, input logic [BW*BN2-1:0] v2, input bit mode);
        int t = 0;
        bit done = 0;
        b_in_valid = 1'b1; b_vec_1 = v1; b_vec_2 = v2; b_in_mode = mode;
        while (!done) begin
            @(negedge clk); #1;
            if (b_in_ready) begin
                b_q.push_back(mk_b(v1, v2, mode));
                done = 1;
            end else if (++t > 200) begin
                checks++; errors++;
                $display("FAIL b_send_timeout: in_ready low for %0d cycles, required 1", t);
                done = 1;
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor A: in_ready rule, stall stability, scoreboard pop; drives out_ready.
    initial begin
        bit held = 0;
        a_exp_t hv;
        int cyc = 0;
        a_out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rstnn) begin
                chk1("a_in_ready", a_in_ready, (a_q.size() < 3) || a_out_ready);
                if (held) begin
                    chk1("a_stall_valid", a_out_valid, 1'b1);
                    checks++;
                    if ({a_mant, a_bump, a_inex} !== hv) begin
                        errors++;
                        $display("FAIL a_stall_hold: got elem0 mant=%h, held mant=%h", a_mant[W-1:0], hv.mant[W-1:0]);
                    end
                end
                held = 0;
                if (a_out_valid) begin
                    if (a_out_ready) begin
                        if (a_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL a_unexpected_output: got out_valid=1, required 0 (nothing pending)");
                        end else cmp_a("a_data", a_q.pop_front());
                    end else begin
                        held = 1;
                        hv = {a_mant, a_bump, a_inex};
                    end
                end
            end else held = 0;
            @(posedge clk); #1;
            cyc++;
            case (a_rmode)
                0: a_out_ready = 1'b1;
                1: a_out_ready = ((cyc % 16) < 6) ? 1'b0 : 1'($urandom_range(0, 1));
                default: a_out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        b_out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rstnn && b_out_valid) begin
                if (b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_output: got out_valid=1, required 0 (nothing pending)");
                end else cmp_b("b_data", b_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  fa, fb;
        logic [BW-1:0] ga, gb;
        logic [W*N1-1:0] r1;
        logic [W*N2-1:0] r2;
        logic [BW*BN1-1:0] s1;
        logic [BW*BN2-1:0] s2;

        rstnn = 1'b0;
        a_in_valid = 0; a_in_mode = 0; a_vec_1 = '0; a_vec_2 = '0;
        b_in_valid = 0; b_in_mode = 0; b_vec_1 = '0; b_vec_2 = '0;
        idle(3);
        rstnn = 1'b1;
        @(negedge clk);
        chk1("rst_out_valid", a_out_valid, 1'b0);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_in_ready", a_in_ready, 1'b1);
        chk1("rst_outputs_zero", (a_mant == '0) && (a_bump == '0) && (a_inex == '0), 1'b1);
        @(posedge clk); #1;

        // Unity and exact latency
        a_send('0, '0, 1'b0);
        @(negedge clk); chk1("lat_c1", a_out_valid, 1'b0);
        @(negedge clk); chk1("lat_c2", a_out_valid, 1'b0);
        @(negedge clk); chk1("lat_c3", a_out_valid, 1'b1);
        @(posedge clk); #1;

        // Directed corners, back to back, both modes
        fa = 23'h400000; fb = 23'h400000;
        a_send({N1{fa}}, {N2{fb}}, 1'b0);
        a_send({N1{fa}}, {N2{fb}}, 1'b1);
        fa = 23'h000001; fb = 23'h400000;
        a_send({N1{fa}}, {N2{fb}}, 1'b0);
        a_send({N1{fa}}, {N2{fb}}, 1'b1);
        fa = 23'h000001; fb = 23'h7FFFFE;
        a_send({N1{fa}}, {N2{fb}}, 1'b0);
        a_send({N1{fa}}, {N2{fb}}, 1'b1);
        idle(6);
        chk1("drain_busy", a_busy, 1'b0);
        chk1("drain_empty", a_q.size() == 0, 1'b1);

        // Randomized stream under backpressure
        a_rmode = 1;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < N1; k++) r1[k*W +: W] = W'(relm(W));
            for (int k = 0; k < N2; k++) r2[k*W +: W] = W'(relm(W));
            a_send(r1, r2, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        a_rmode = 0;
        idle(12);
        chk1("bp_drain_empty", a_q.size() == 0, 1'b1);

        // Reset with three in flight
        a_rmode = 2;
        idle(2);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < N1; k++) r1[k*W +: W] = W'(relm(W));
            a_send(r1, r1, 1'b1);
        end
        idle(2);
        chk1("full_busy", a_busy, 1'b1);
        rstnn = 1'b0;
        idle(1);
        rstnn = 1'b1;
        a_q.delete();
        b_q.delete();
        @(negedge clk);
        chk1("mid_rst_out_valid", a_out_valid, 1'b0);
        chk1("mid_rst_busy", a_busy, 1'b0);
        chk1("mid_rst_zero", (a_mant == '0) && (a_bump == '0) && (a_inex == '0), 1'b1);
        @(posedge clk); #1;
        a_rmode = 0;
        idle(8);
        chk1("post_rst_busy", a_busy, 1'b0);

        // Small configuration
        b_send('0, '0, 1'b0);
        ga = 10'h200; gb = 10'h200;
        b_send({BN1{ga}}, {BN2{gb}}, 1'b0);
        b_send({BN1{ga}}, {BN2{gb}}, 1'b1);
        ga = 10'h001; gb = 10'h200;
        b_send({BN1{ga}}, {BN2{gb}}, 1'b0);
        b_send({BN1{ga}}, {BN2{gb}}, 1'b1);
        ga = 10'h001; gb = 10'h3FE;
        b_send({BN1{ga}}, {BN2{gb}}, 1'b0);
        b_send({BN1{ga}}, {BN2{gb}}, 1'b1);
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < BN1; k++) s1[k*BW +: BW] = BW'(relm(BW));
            for (int k = 0; k < BN2; k++) s2[k*BW +: BW] = BW'(relm(BW));
            b_send(s1, s2, 1'($urandom_range(0, 1)));
        end
        idle(8);
        chk1("b_drain_empty", b_q.size() == 0, 1'b1);
        chk1("b_drain_busy", b_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
